// File: rtl/regfile_test_port_if.sv
// Purpose: bundles the regfile access controller's bus signals. It covers the
//   processor and test-port regfile controls, the muxed regfile controls, the
//   stall/ownership handshake and the write-back trace FIFO read side.
// Ports (signals):
//   test                         harness requests regfile ownership (level)
//   p_we/p_wreg/p_rreg*/p_wdata  processor regfile controls
//   t_we/t_wreg/t_rreg*/t_wdata  test-port regfile controls
//   r_we/r_wreg/r_rreg*/r_wdata  muxed controls toward the regfile
//   p_stall, t_ready             processor hold / test-port ownership
//   trace_pop, trace_clear       trace FIFO consume / flush
//   trace_valid/reg/data/count/overflow  trace FIFO head and status
// Modports: slave = controller, master = processor/harness side.
interface regfile_test_port_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              test;
  logic              p_we;
  logic [REG_W-1:0]  p_wreg;
  logic [REG_W-1:0]  p_rregA;
  logic [REG_W-1:0]  p_rregB;
  logic [DATA_W-1:0] p_wdata;
  logic              t_we;
  logic [REG_W-1:0]  t_wreg;
  logic [REG_W-1:0]  t_rregA;
  logic [REG_W-1:0]  t_rregB;
  logic [DATA_W-1:0] t_wdata;
  logic              r_we;
  logic [REG_W-1:0]  r_wreg;
  logic [REG_W-1:0]  r_rregA;
  logic [REG_W-1:0]  r_rregB;
  logic [DATA_W-1:0] r_wdata;
  logic              p_stall;
  logic              t_ready;
  logic              trace_pop;
  logic              trace_clear;
  logic              trace_valid;
  logic [REG_W-1:0]  trace_reg;
  logic [DATA_W-1:0] trace_data;
  logic [CNT_W-1:0]  trace_count;
  logic              trace_overflow;

  modport slave (
    input  test, p_we, p_wreg, p_rregA, p_rregB, p_wdata,
           t_we, t_wreg, t_rregA, t_rregB, t_wdata,
           trace_pop, trace_clear,
    output r_we, r_wreg, r_rregA, r_rregB, r_wdata, p_stall, t_ready,
           trace_valid, trace_reg, trace_data, trace_count, trace_overflow
  );

  modport master (
    output test, p_we, p_wreg, p_rregA, p_rregB, p_wdata,
           t_we, t_wreg, t_rregA, t_rregB, t_wdata,
           trace_pop, trace_clear,
    input  r_we, r_wreg, r_rregA, r_rregB, r_wdata, p_stall, t_ready,
           trace_valid, trace_reg, trace_data, trace_count, trace_overflow
  );
endinterface

// File: rtl/regfile_test_port.sv
// Purpose: arbitrates regfile access between the processor and the board test
//   harness. A four-state handoff FSM stalls the processor before the test
//   port takes the regfile. Every traced processor write-back is captured into
//   a FIFO that the harness reads back.
// Ports:
//   clock  single clock, rising edge
//   reset  synchronous, active-high
//   bus    regfile_test_port_if.slave (processor/test/regfile/trace signals)
module regfile_test_port #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 16
) (
  input logic               clock,
  input logic               reset,
  regfile_test_port_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {RUN, HANDOFF, TEST, RETURN} state_t;

  state_t stateQ;
  state_t stateNext;

  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  countQ;
  logic              overflowQ;
  logic [REG_W-1:0]  memReg  [DEPTH];
  logic [DATA_W-1:0] memData [DEPTH];

  logic pushReq;
  logic fifoFull;
  logic fifoEmpty;
  logic doPop;
  logic doPush;

  always_ff @(posedge clock) begin
    if (reset) stateQ <= RUN;
    else       stateQ <= stateNext;
  end

  // HANDOFF and RETURN are bubble cycles: reads point at the incoming owner
  // while writes stay blocked, so neither side writes during the switch.
  always_comb begin
    stateNext    = stateQ;
    bus.r_we     = 1'b0;
    bus.r_wreg   = bus.p_wreg;
    bus.r_wdata  = bus.p_wdata;
    bus.r_rregA  = bus.p_rregA;
    bus.r_rregB  = bus.p_rregB;
    bus.p_stall  = 1'b1;
    bus.t_ready  = 1'b0;
    case (stateQ)
      RUN: begin
        bus.r_we    = bus.p_we;
        bus.p_stall = 1'b0;
        if (bus.test) stateNext = HANDOFF;
      end
      HANDOFF: begin
        bus.r_wreg  = bus.t_wreg;
        bus.r_wdata = bus.t_wdata;
        bus.r_rregA = bus.t_rregA;
        bus.r_rregB = bus.t_rregB;
        stateNext   = bus.test ? TEST : RETURN;
      end
      TEST: begin
        bus.r_we    = bus.t_we;
        bus.r_wreg  = bus.t_wreg;
        bus.r_wdata = bus.t_wdata;
        bus.r_rregA = bus.t_rregA;
        bus.r_rregB = bus.t_rregB;
        bus.t_ready = 1'b1;
        if (!bus.test) stateNext = RETURN;
      end
      RETURN: begin
        stateNext = RUN;
      end
      default: begin
        stateNext = RUN;
      end
    endcase
    // No regfile write may slip through while reset is held, whatever state.
    if (reset) bus.r_we = 1'b0;
  end

  // Only processor write-backs to non-zero registers are traced.
  assign pushReq   = (stateQ == RUN) && bus.p_we && (bus.p_wreg != '0);
  assign fifoFull  = (countQ == CNT_W'(DEPTH));
  assign fifoEmpty = (countQ == '0);
  assign doPop     = bus.trace_pop && !fifoEmpty;
  // When full, a simultaneous pop frees the head slot, which wrPtr aliases.
  assign doPush    = pushReq && (!fifoFull || doPop);

  always_ff @(posedge clock) begin
    if (reset || bus.trace_clear) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      countQ    <= '0;
      overflowQ <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + CNT_W'(1);
        2'b01:   countQ <= countQ - CNT_W'(1);
        default: countQ <= countQ;
      endcase
      if (pushReq && fifoFull && !doPop) overflowQ <= 1'b1;
    end
  end

  // Storage holds data only; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (doPush) begin
      memReg[wrPtr]  <= bus.p_wreg;
      memData[wrPtr] <= bus.p_wdata;
    end
  end

  assign bus.trace_valid    = !fifoEmpty;
  assign bus.trace_reg      = memReg[rdPtr];
  assign bus.trace_data     = memData[rdPtr];
  assign bus.trace_count    = countQ;
  assign bus.trace_overflow = overflowQ;
endmodule

// File: tb/tb_regfile_test_port.sv
// Purpose: self-checking bench for regfile_test_port. A constant vector table
//   walks the handoff FSM. A scoreboard queue holds expected trace entries.
//   Hand sequences cover overflow, clear and reset corners.
module tb_regfile_test_port;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 8;

  logic clock;
  logic reset;

  regfile_test_port_if #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) bus ();

  regfile_test_port #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [REG_W-1:0]  r;
    logic [DATA_W-1:0] d;
  } ent_t;

  typedef struct {
    bit test;
    bit pWe;
    bit tWe;
    bit stall;
    bit ready;
    bit rwe;
    bit srcT;
  } vec_t;

  ent_t  sb[$];
  bit    expOvf;
  int    checks;
  int    errors;
  vec_t  vecs[12];
  logic [DATA_W-1:0] rf [32];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in regfile so test-port reads can be checked after a write.
  always @(posedge clock) begin
    if (bus.r_we) rf[bus.r_wreg] <= bus.r_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic modelPush(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
    ent_t e;
    if (r != '0) begin
      if (sb.size() < DEPTH) begin
        e.r = r;
        e.d = d;
        sb.push_back(e);
      end else begin
        expOvf = 1'b1;
      end
    end
  endtask

  task automatic pWrite(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
    bus.p_we    = 1'b1;
    bus.p_wreg  = r;
    bus.p_wdata = d;
    settle();
    modelPush(r, d);
    tick();
    bus.p_we = 1'b0;
  endtask

  task automatic popCheck(input string name);
    ent_t e;
    settle();
    if (sb.size() == 0) begin
      check({name, "_valid_empty"}, bus.trace_valid, 1'b0);
    end else begin
      e = sb.pop_front();
      check({name, "_valid"}, bus.trace_valid, 1'b1);
      check({name, "_reg"}, bus.trace_reg, e.r);
      check({name, "_data"}, bus.trace_data, e.d);
    end
    bus.trace_pop = 1'b1;
    tick();
    bus.trace_pop = 1'b0;
  endtask

  task automatic checkFifo(input string name);
    settle();
    check({name, "_count"}, bus.trace_count, sb.size());
    check({name, "_valid"}, bus.trace_valid, sb.size() != 0);
    check({name, "_ovf"}, bus.trace_overflow, expOvf);
  endtask

  initial begin
    ent_t e;
    checks = 0;
    errors = 0;
    expOvf = 1'b0;
    reset = 1'b1;
    bus.test = 1'b0;
    bus.p_we = 1'b1; bus.p_wreg = 5'd3; bus.p_rregA = '0; bus.p_rregB = '0; bus.p_wdata = '0;
    bus.t_we = 1'b1; bus.t_wreg = '0; bus.t_rregA = '0; bus.t_rregB = '0; bus.t_wdata = '0;
    bus.trace_pop = 1'b0; bus.trace_clear = 1'b0;

    //              test pWe tWe stall ready rwe srcT
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset: regfile write blocked even with p_we and t_we high.
    tick();
    tick();
    settle();
    check("reset_rwe", bus.r_we, 1'b0);
    check("reset_stall", bus.p_stall, 1'b0);
    check("reset_ready", bus.t_ready, 1'b0);
    checkFifo("reset");
    bus.p_we = 1'b0;
    bus.t_we = 1'b0;
    reset = 1'b0;
    tick();

    // Processor write-backs; r0 is not traced.
    pWrite(5'd3, 32'h11);
    pWrite(5'd0, 32'h99);
    pWrite(5'd7, 32'h22);
    checkFifo("trace3");
    check("trace3_count_const", bus.trace_count, 2);
    popCheck("pop0");
    popCheck("pop1");
    checkFifo("trace3_drained");

    // Test-port access: write r5, read it back, no trace entries.
    bus.test = 1'b1;
    settle();
    tick();
    bus.p_we = 1'b1; bus.p_wreg = 5'd9; bus.p_wdata = 32'h5555;
    settle();
    check("handoff_stall", bus.p_stall, 1'b1);
    check("handoff_ready", bus.t_ready, 1'b0);
    tick();
    bus.t_we = 1'b1; bus.t_wreg = 5'd5; bus.t_wdata = 32'hABCD;
    settle();
    check("test_ready", bus.t_ready, 1'b1);
    check("test_rwe", bus.r_we, 1'b1);
    check("test_rwreg", bus.r_wreg, 5'd5);
    tick();
    bus.t_we = 1'b0; bus.t_rregA = 5'd5;
    settle();
    check("test_rregA", bus.r_rregA, 5'd5);
    check("test_rdata", rf[bus.r_rregA], 32'hABCD);
    bus.test = 1'b0;
    tick();
    settle();
    check("return_stall", bus.p_stall, 1'b1);
    check("return_rwe", bus.r_we, 1'b0);
    bus.p_we = 1'b0;
    tick();
    settle();
    check("run_stall", bus.p_stall, 1'b0);
    checkFifo("test_notrace");

    // Table-driven walk: long ownership, then a 1-cycle test pulse.
    bus.p_wreg = '0;
    bus.p_rregA = 5'd1; bus.p_rregB = 5'd3;
    bus.t_rregA = 5'd2; bus.t_rregB = 5'd4;
    for (int i = 0; i < 12; i++) begin
      bus.test = vecs[i].test;
      bus.p_we = vecs[i].pWe;
      bus.t_we = vecs[i].tWe;
      settle();
      check($sformatf("vec%0d_stall", i), bus.p_stall, vecs[i].stall);
      check($sformatf("vec%0d_ready", i), bus.t_ready, vecs[i].ready);
      check($sformatf("vec%0d_rwe", i), bus.r_we, vecs[i].rwe);
      check($sformatf("vec%0d_rregA", i), bus.r_rregA, vecs[i].srcT ? 5'd2 : 5'd1);
      check($sformatf("vec%0d_rregB", i), bus.r_rregB, vecs[i].srcT ? 5'd4 : 5'd3);
      tick();
    end
    checkFifo("table_notrace");

    // Overflow: DEPTH+1 writes without popping.
    for (int i = 0; i <= DEPTH; i++) pWrite(5'(i + 1), 32'h100 + i);
    checkFifo("full");
    check("full_count_const", bus.trace_count, DEPTH);
    check("full_ovf_const", bus.trace_overflow, 1'b1);
    check("full_head_reg", bus.trace_reg, 5'd1);
    check("full_head_data", bus.trace_data, 32'h100);

    // Full: push and pop together keeps count at DEPTH.
    bus.p_we = 1'b1; bus.p_wreg = 5'd20; bus.p_wdata = 32'hBEEF;
    bus.trace_pop = 1'b1;
    settle();
    e = sb.pop_front();
    check("fullpp_head_reg", bus.trace_reg, e.r);
    check("fullpp_head_data", bus.trace_data, e.d);
    modelPush(5'd20, 32'hBEEF);
    tick();
    bus.p_we = 1'b0; bus.trace_pop = 1'b0;
    checkFifo("fullpp");
    for (int i = 0; i < DEPTH; i++) popCheck($sformatf("drain%0d", i));
    checkFifo("drained");

    // Empty: push and pop together stores the push.
    bus.p_we = 1'b1; bus.p_wreg = 5'd6; bus.p_wdata = 32'h66;
    bus.trace_pop = 1'b1;
    settle();
    check("emptypp_valid", bus.trace_valid, 1'b0);
    modelPush(5'd6, 32'h66);
    tick();
    bus.p_we = 1'b0; bus.trace_pop = 1'b0;
    checkFifo("emptypp");
    popCheck("emptypp_pop");

    // Clear beats simultaneous push and pop, and drops overflow.
    pWrite(5'd10, 32'hA0);
    pWrite(5'd11, 32'hA1);
    pWrite(5'd12, 32'hA2);
    checkFifo("preclear");
    bus.p_we = 1'b1; bus.p_wreg = 5'd8; bus.p_wdata = 32'h88;
    bus.trace_pop = 1'b1; bus.trace_clear = 1'b1;
    settle();
    tick();
    bus.p_we = 1'b0; bus.trace_pop = 1'b0; bus.trace_clear = 1'b0;
    sb.delete();
    expOvf = 1'b0;
    checkFifo("clear");

    // Reset while in TEST with 5 entries stored.
    for (int i = 0; i < 5; i++) pWrite(5'(i + 1), 32'h200 + i);
    checkFifo("prereset");
    bus.test = 1'b1;
    settle();
    tick();
    tick();
    settle();
    check("prereset_ready", bus.t_ready, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.test = 1'b0;
    sb.delete();
    expOvf = 1'b0;
    settle();
    check("postreset_stall", bus.p_stall, 1'b0);
    check("postreset_ready", bus.t_ready, 1'b0);
    checkFifo("postreset");
    bus.p_we = 1'b1; bus.p_wreg = '0;
    settle();
    check("postreset_rwe", bus.r_we, 1'b1);
    tick();
    bus.p_we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_test_port.md
# regfile_test_port

Arbitrated register-file access controller with a write-back trace buffer, placed between the processor, the regfile and the board-level test harness in the processor top level. Replaces the level-switched test mux with a clean handoff state machine that stalls the processor before the test port takes the regfile. It also captures every processor regfile write into a FIFO so the harness can read back the execution trace.

## Interface
Parameters:
- DATA_W, 32, regfile data width
- REG_W, 5, register index width
- DEPTH, 16, trace FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- test  in  1  harness requests regfile ownership (level)
- p_we / p_wreg / p_rregA / p_rregB / p_wdata  in  1/REG_W/REG_W/REG_W/DATA_W  processor regfile controls
- t_we / t_wreg / t_rregA / t_rregB / t_wdata  in  1/REG_W/REG_W/REG_W/DATA_W  test-port regfile controls
- r_we / r_wreg / r_rregA / r_rregB / r_wdata  out  1/REG_W/REG_W/REG_W/DATA_W  to regfile
- p_stall  out  1  processor must hold its state, including any pending write-back
- t_ready  out  1  test port owns regfile this cycle
- trace_pop  in  1  consume head entry
- trace_clear  in  1  empty FIFO and clear overflow
- trace_valid  out  1  FIFO non-empty
- trace_reg / trace_data  out  REG_W/DATA_W  head entry (don't-care when empty)
- trace_count  out  log2(DEPTH)+1  occupancy
- trace_overflow  out  1  sticky: a push was dropped

## Operation
- FSM states RUN, HANDOFF, TEST, RETURN; reset → RUN.
- RUN: r_* = p_*; p_stall=0; t_ready=0. test=1 → HANDOFF.
- HANDOFF: p_stall=1; r_we=0; r_rreg* = t_rreg*. test=1 → TEST; test=0 → RETURN.
- TEST: r_* = t_*; p_stall=1; t_ready=1. test=0 → RETURN.
- RETURN: p_stall=1; r_we=0; r_rreg* = p_rreg*. Always → RUN.
- Trace push = state RUN & p_we & p_wreg≠0; entry {p_wreg, p_wdata}. Writes to r0 are not traced. Test-port writes are never traced.
- Pop = trace_pop & trace_valid; pop on empty ignored.
- Full & push & no pop: entry dropped, trace_overflow←1.
- Full & push & pop: both occur, count unchanged, no overflow.
- Empty & push & pop: pop ignored, push stored.
- trace_clear has priority over push/pop that cycle: pointers and count ←0, overflow ←0.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is combinational from pointers plus a wrap bit, or registered; it must be exact at DEPTH.
- The r_* mux and the FIFO head outputs are combinational from registered state/storage. Storage is a register array (no RAM inference requirement).

## Timing
- Reset values: state RUN, p_stall 0, t_ready 0, trace_valid 0, trace_count 0, trace_overflow 0; r_we 0 during reset.
- Reset mid-operation (any state, any FIFO fill): next cycle RUN, FIFO empty; stored entries are discarded.
- test rise in cycle n (RUN): HANDOFF at n+1, first t_ready at n+2. Test latency is 2 cycles.
- test fall in TEST at cycle m: RETURN at m+1, RUN at m+2; p_stall deasserts at m+2.
- Test-port inputs are ignored except when t_ready=1.
- A test pulse of 1 cycle gives RUN→HANDOFF→RETURN→RUN with no test access; p_stall is high for 2 cycles.
- Push/pop take effect at the clock edge. The new head is visible the next cycle. A pushed entry is visible on trace_* one cycle after the push into an empty FIFO.

## Test plan
- Reset, then processor writes r3=0x11, r0=0x99, r7=0x22 in RUN → count 2; pops return (3,0x11) then (7,0x22); trace_valid 0 after.
- test rises at cycle 10 → p_stall 1 at 11, t_ready 1 at 12; t_we r5=0xABCD at 12, then t_rregA=5 → r_data 0xABCD; test falls at 14 → RUN at 16, no trace entries added.
- Push DEPTH+1 writes without popping → count DEPTH, overflow 1, head = first write; then push and pop in the same cycle while full → count DEPTH, new tail correct.
- trace_clear asserted together with push and pop → count 0, overflow 0, trace_valid 0 next cycle.
- 1-cycle test pulse → states HANDOFF, RETURN, RUN; r_we 0 in both middle cycles even with p_we=1 and t_we=1.
- reset asserted while in TEST with 5 entries stored → next cycle RUN, p_stall 0, t_ready 0, count 0.
